int_ctrl: RTL and testbench

//  Machine-mode trap sequencer for the pipelined core.
//  - Detects synchronous traps (ecall/ebreak) from the ID-stage instruction and asynchronous

---
 rtl/int_ctrl.sv | 160 ++++++++++++++++
 tb/tb_int_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: machine-mode trap sequencer for the pipelined core.
//
// Takes ecall/ebreak from the ID-stage instruction and level-sensitive external
// interrupts. It stalls the pipeline, then writes mepc, mcause and mstatus
// through a dedicated CSR port, one CSR per cycle. After that it issues a
// one-cycle PC redirect to mtvec. An mret is handled the same way: it restores
// MIE from MPIE, then redirects to mepc.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   int_flag_i          level interrupt requests (bit set = pending)
//   inst_i, inst_addr_i ID-stage instruction and its PC
//   jump_flag_i/addr_i  EX-stage redirect in progress and its target
//   halt_i              debug halt; blocks acceptance of new traps
//   csr_mtvec_i/mepc_i/mstatus_i  current CSR values
//   hold_flag_o         pipeline stall request
//   csr_we_o/waddr_o/wdata_o      CSR write port
//   int_assert_o/int_addr_o       one-cycle PC redirect and its target
module int_ctrl #(
  parameter int XLEN  = 32,
  parameter int INT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INT_W-1:0] int_flag_i,
  input  logic [XLEN-1:0]  inst_i,
  input  logic [XLEN-1:0]  inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [XLEN-1:0]  jump_addr_i,
  input  logic             halt_i,
  input  logic [XLEN-1:0]  csr_mtvec_i,
  input  logic [XLEN-1:0]  csr_mepc_i,
  input  logic [XLEN-1:0]  csr_mstatus_i,
  output logic             hold_flag_o,
  output logic             csr_we_o,
  output logic [11:0]      csr_waddr_o,
  output logic [XLEN-1:0]  csr_wdata_o,
  output logic             int_assert_o,
  output logic [XLEN-1:0]  int_addr_o
);

  localparam logic [XLEN-1:0] INST_ECALL  = XLEN'(32'h0000_0073);
  localparam logic [XLEN-1:0] INST_EBREAK = XLEN'(32'h0010_0073);
  localparam logic [XLEN-1:0] INST_MRET   = XLEN'(32'h3020_0073);
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    S_IDLE, S_MEPC, S_MCAUSE, S_MSTATUS, S_MRET, S_JUMP
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic            mret_q, mret_d;   // JUMP targets mepc instead of mtvec

  logic is_ecall, is_ebreak, is_mret, is_async;

  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_mret   = (inst_i == INST_MRET);
  assign is_async  = (|int_flag_i) & csr_mstatus_i[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      epc_q   <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    mret_d       = mret_q;
    hold_flag_o  = 1'b0;
    csr_we_o     = 1'b0;
    csr_waddr_o  = '0;
    csr_wdata_o  = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;

    unique case (state_q)
      S_IDLE: begin
        // Acceptance raises hold in the same cycle so the ID instruction
        // does not advance past the trap point.
        if (!halt_i) begin
          if (is_ecall || is_ebreak) begin
            hold_flag_o = 1'b1;
            epc_d       = inst_addr_i;
            cause_d     = is_ecall ? XLEN'(11) : XLEN'(3);
            mret_d      = 1'b0;
            state_d     = S_MEPC;
          end else if (is_async) begin
            // A redirect in EX means inst_addr_i is on a squashed path;
            // resume at the branch target instead.
            hold_flag_o = 1'b1;
            epc_d       = jump_flag_i ? jump_addr_i : inst_addr_i;
            cause_d     = XLEN'(32'h8000_000B);
            mret_d      = 1'b0;
            state_d     = S_MEPC;
          end else if (is_mret) begin
            hold_flag_o = 1'b1;
            mret_d      = 1'b1;
            state_d     = S_MRET;
          end
        end
      end
      S_MEPC: begin
        hold_flag_o = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MEPC;
        csr_wdata_o = epc_q;
        state_d     = S_MCAUSE;
      end
      S_MCAUSE: begin
        hold_flag_o = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MCAUSE;
        csr_wdata_o = cause_q;
        state_d     = S_MSTATUS;
      end
      S_MSTATUS: begin
        // MPIE <= MIE, MIE <= 0
        hold_flag_o = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = {csr_mstatus_i[XLEN-1:8], csr_mstatus_i[3],
                       csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
        state_d     = S_JUMP;
      end
      S_MRET: begin
        // MIE <= MPIE, MPIE <= 1
        hold_flag_o = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = {csr_mstatus_i[XLEN-1:8], 1'b1,
                       csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};
        state_d     = S_JUMP;
      end
      S_JUMP: begin
        hold_flag_o  = 1'b1;
        int_assert_o = 1'b1;
        int_addr_o   = mret_q ? csr_mepc_i : csr_mtvec_i;
        mret_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  logic        clk, rst_n;
  logic [7:0]  int_flag_i;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i, halt_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        hold_flag_o, csr_we_o, int_assert_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o, int_addr_o;

  int n_vec = 0;
  int n_err = 0;

  int_ctrl #(.XLEN(32), .INT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .int_flag_i(int_flag_i), .inst_i(inst_i),
    .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .halt_i(halt_i), .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
    .csr_mstatus_i(csr_mstatus_i), .hold_flag_o(hold_flag_o), .csr_we_o(csr_we_o),
    .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Compare every output against one expected vector.
  task automatic expect_out(input string tag, input logic h, input logic we,
                            input logic [11:0] wa, input logic [31:0] wd,
                            input logic ia, input logic [31:0] iaddr);
    chk({tag, ".hold"},  {31'd0, hold_flag_o}, {31'd0, h});
    chk({tag, ".we"},    {31'd0, csr_we_o}, {31'd0, we});
    chk({tag, ".waddr"}, {20'd0, csr_waddr_o}, {20'd0, wa});
    chk({tag, ".wdata"}, csr_wdata_o, wd);
    chk({tag, ".assert"},{31'd0, int_assert_o}, {31'd0, ia});
    chk({tag, ".iaddr"}, int_addr_o, iaddr);
  endtask

  // Move to the next cycle's sample point, away from the posedge.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; int_flag_i = '0; inst_i = NOP; inst_addr_i = 32'h0;
    jump_flag_i = 1'b0; jump_addr_i = '0; halt_i = 1'b0;
    csr_mtvec_i = 32'h80; csr_mepc_i = 32'h0; csr_mstatus_i = 32'h8;
    #12;
    expect_out("reset", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    nxt(); expect_out("idle", 0, 0, 12'h0, 32'h0, 0, 32'h0);

    // 1: ecall at 0x100, MIE=1
    @(negedge clk); inst_i = ECALL; inst_addr_i = 32'h100; #1;
    expect_out("t1.T",   1, 0, 12'h0,   32'h0,  0, 32'h0);
    @(negedge clk); inst_i = NOP; #1;
    expect_out("t1.T1",  1, 1, 12'h341, 32'h100, 0, 32'h0);
    nxt(); expect_out("t1.T2", 1, 1, 12'h342, 32'd11, 0, 32'h0);
    nxt(); expect_out("t1.T3", 1, 1, 12'h300, 32'h80, 0, 32'h0);
    nxt(); expect_out("t1.T4", 1, 0, 12'h0,   32'h0,  1, 32'h80);
    nxt(); expect_out("t1.T5", 0, 0, 12'h0,   32'h0,  0, 32'h0);

    // 2: async with EX redirect in flight
    @(negedge clk); int_flag_i = 8'h04; jump_flag_i = 1'b1; jump_addr_i = 32'h200;
    inst_addr_i = 32'h300; #1;
    expect_out("t2.T", 1, 0, 12'h0, 32'h0, 0, 32'h0);
    @(negedge clk); int_flag_i = '0; jump_flag_i = 1'b0; #1;
    expect_out("t2.T1", 1, 1, 12'h341, 32'h200, 0, 32'h0);
    nxt(); expect_out("t2.T2", 1, 1, 12'h342, 32'h8000_000B, 0, 32'h0);
    nxt(); expect_out("t2.T3", 1, 1, 12'h300, 32'h80, 0, 32'h0);
    nxt(); expect_out("t2.T4", 1, 0, 12'h0, 32'h0, 1, 32'h80);
    nxt(); expect_out("t2.T5", 0, 0, 12'h0, 32'h0, 0, 32'h0);

    // 3: masked request, then halted request
    @(negedge clk); csr_mstatus_i = 32'h0; int_flag_i = 8'h01; #1;
    expect_out("t3.mask", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    nxt(); expect_out("t3.mask2", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    @(negedge clk); csr_mstatus_i = 32'h8; halt_i = 1'b1; #1;
    expect_out("t3.halt", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    nxt(); expect_out("t3.halt2", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    @(negedge clk); int_flag_i = '0; halt_i = 1'b0; #1;

    // 4: mret, MPIE=1 MIE=0, mepc=0x104
    @(negedge clk); csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104; inst_i = MRET; #1;
    expect_out("t4.T", 1, 0, 12'h0, 32'h0, 0, 32'h0);
    @(negedge clk); inst_i = NOP; #1;
    expect_out("t4.T1", 1, 1, 12'h300, 32'h88, 0, 32'h0);
    nxt(); expect_out("t4.T2", 1, 0, 12'h0, 32'h0, 1, 32'h104);
    nxt(); expect_out("t4.T3", 0, 0, 12'h0, 32'h0, 0, 32'h0);

    // 5: ebreak coincident with async, MIE=1
    @(negedge clk); csr_mstatus_i = 32'h8; inst_i = EBREAK; inst_addr_i = 32'h400;
    int_flag_i = 8'h80; #1;
    expect_out("t5.T", 1, 0, 12'h0, 32'h0, 0, 32'h0);
    @(negedge clk); inst_i = NOP; #1;
    expect_out("t5.T1", 1, 1, 12'h341, 32'h400, 0, 32'h0);
    nxt(); expect_out("t5.T2", 1, 1, 12'h342, 32'd3, 0, 32'h0);
    nxt(); expect_out("t5.T3", 1, 1, 12'h300, 32'h80, 0, 32'h0);
    @(negedge clk); csr_mstatus_i = 32'h80; #1;   // CSR file reflects the write
    expect_out("t5.T4", 1, 0, 12'h0, 32'h0, 1, 32'h80);
    nxt(); expect_out("t5.T5", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    nxt(); expect_out("t5.T6", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    @(negedge clk); int_flag_i = '0; csr_mstatus_i = 32'h8; #1;

    // 6: reset pulse during MCAUSE
    @(negedge clk); inst_i = ECALL; inst_addr_i = 32'h500; #1;
    @(negedge clk); inst_i = NOP; #1;
    expect_out("t6.T1", 1, 1, 12'h341, 32'h500, 0, 32'h0);
    @(negedge clk); #1;
    expect_out("t6.T2", 1, 1, 12'h342, 32'd11, 0, 32'h0);
    rst_n = 1'b0; #1;
    expect_out("t6.rst", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      expect_out("t6.after", 0, 0, 12'h0, 32'h0, 0, 32'h0);
      nxt();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
